// File: rtl/timer_1us_tick.sv
// Free-running tick generator: a one-cycle o_q pulse every SPEED microseconds,
// derived from a CLK_PER_US prescaler. Define TIMER_1US_TICK_ASSERT_EN to compile in checks.
module timer_1us_tick #(
    parameter int SPEED      = 1,
    parameter int CLK_PER_US = 25
) (
    input  logic i_clk_25MHz,
    input  logic i_reset,
    output logic o_q
);

    localparam int PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int US_W  = (SPEED > 1) ? $clog2(SPEED) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_US - 1);
    localparam logic [US_W-1:0]  US_LAST  = US_W'(SPEED - 1);

    logic [PRE_W-1:0] r_pre;
    logic [US_W-1:0]  r_us;
    logic             r_q_p1;

    logic             w_pre_last;
    logic             w_terminal;
    logic [PRE_W-1:0] w_pre_nxt;
    logic [US_W-1:0]  w_us_nxt;

    // Out-of-range counter values fall back to 0 rather than running on.
    always_comb begin
        w_pre_last = (r_pre == PRE_LAST);
        w_terminal = w_pre_last && (r_us == US_LAST);

        w_pre_nxt = r_pre + PRE_W'(1);
        if (w_pre_last || (r_pre > PRE_LAST)) begin
            w_pre_nxt = '0;
        end

        w_us_nxt = r_us;
        if (r_us > US_LAST) begin
            w_us_nxt = '0;
        end else if (w_pre_last) begin
            w_us_nxt = (r_us == US_LAST) ? '0 : (r_us + US_W'(1));
        end
    end

    // Stage p1: counters and the registered tick
    always_ff @(posedge i_clk_25MHz or posedge i_reset) begin
        if (i_reset) begin
            r_pre  <= '0;
            r_us   <= '0;
            r_q_p1 <= 1'b0;
        end else begin
            r_pre  <= w_pre_nxt;
            r_us   <= w_us_nxt;
            r_q_p1 <= w_terminal;
        end
    end

    assign o_q = r_q_p1;

`ifdef TIMER_1US_TICK_ASSERT_EN
    if (SPEED < 1) begin : g_bad_speed
        $error("timer_1us_tick: SPEED must be >= 1");
    end
    if (CLK_PER_US < 1) begin : g_bad_clk
        $error("timer_1us_tick: CLK_PER_US must be >= 1");
    end

    a_pre_range: assert property (@(posedge i_clk_25MHz) disable iff (i_reset)
        r_pre <= PRE_LAST);
    a_us_range: assert property (@(posedge i_clk_25MHz) disable iff (i_reset)
        r_us <= US_LAST);
    a_q_on_terminal: assert property (@(posedge i_clk_25MHz) disable iff (i_reset)
        $rose(r_q_p1) |-> $past(w_terminal));

    if ((SPEED * CLK_PER_US) > 1) begin : g_single_cycle
        a_q_one_wide: assert property (@(posedge i_clk_25MHz) disable iff (i_reset)
            r_q_p1 |=> !r_q_p1);
    end
`else
`endif

endmodule

// File: tb/tb_timer_1us_tick.sv
// Scoreboard bench: several timer instances with different periods, randomized
// reset activity, expected tick computed from "edges since release mod N".
module tb_timer_1us_tick;

    localparam int NDUT = 5;
    localparam int SP[NDUT] = '{1, 4, 3, 2, 1};
    localparam int CP[NDUT] = '{25, 25, 5, 5, 1};
    localparam int NCYC = 3000;
    localparam int QUIET_CYC = 600;
    localparam int WAIT_DUT = 1;

    logic            clk;
    logic [NDUT-1:0] rst;
    logic [NDUT-1:0] q;

    int              cnt[NDUT];
    logic [NDUT-1:0] exp_q[$];
    int              n_checks;
    int              n_pass;
    bit              done;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        timer_1us_tick #(
            .SPEED     (SP[g]),
            .CLK_PER_US(CP[g])
        ) u_dut (
            .i_clk_25MHz(clk),
            .i_reset    (rst[g]),
            .o_q        (q[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit model_tick(input int edges, input int n);
        return (edges > 0) && ((edges % n) == 0);
    endfunction

    // Stimulus: reset activity is changed 2 time units after each rising edge,
    // so asserting it during a pulse must clear o_q before the next falling edge.
    initial begin
        logic [NDUT-1:0] e;
        bit              pulse;
        int              n;
        int              wait_n;
        int              k;
        bit              seen;
        done     = 1'b0;
        n_checks = 0;
        n_pass   = 0;
        rst      = '1;
        for (int g = 0; g < NDUT; g++) cnt[g] = 0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            for (int g = 0; g < NDUT; g++) begin
                if (!rst[g]) cnt[g]++;
            end
            #2;
            for (int g = 0; g < NDUT; g++) begin
                n = SP[g] * CP[g];
                pulse = !rst[g] && model_tick(cnt[g], n);
                if (rst[g]) begin
                    if ($urandom_range(0, 2) == 0) rst[g] = 1'b0;
                end else if (cyc >= QUIET_CYC) begin
                    if (pulse ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 299) == 0))
                        rst[g] = 1'b1;
                end
                if (rst[g]) cnt[g] = 0;
                e[g] = !rst[g] && model_tick(cnt[g], n);
            end
            exp_q.push_back(e);
        end

        @(negedge clk);
        @(negedge clk);
        done = 1'b1;

        @(posedge clk);
        #2;
        rst = '1;
        #1;
        for (int g = 0; g < NDUT; g++) begin
            n_checks++;
            if (q[g] !== 1'b0) begin
                $display("FAIL reset dut%0d at %0t: o_q=%b expected=0 while in reset",
                         g, $time, q[g]);
            end else begin
                n_pass++;
            end
        end

        @(posedge clk);
        @(posedge clk);
        #2;
        rst[WAIT_DUT] = 1'b0;
        wait_n = SP[WAIT_DUT] * CP[WAIT_DUT];
        seen = 1'b0;
        k = 0;
        while (!seen && k < 2 * wait_n) begin
            @(posedge clk);
            k++;
            #1;
            if (q[WAIT_DUT] === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            $display("FAIL wait dut%0d at %0t: no pulse within %0d edges after release",
                     WAIT_DUT, $time, 2 * wait_n);
        end else if (k != wait_n) begin
            $display("FAIL wait dut%0d at %0t: first pulse after edge %0d, expected %0d",
                     WAIT_DUT, $time, k, wait_n);
        end else begin
            n_pass++;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Monitor: one expected vector per cycle, compared mid-cycle.
    always @(negedge clk) begin
        logic [NDUT-1:0] e;
        if (!done && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int g = 0; g < NDUT; g++) begin
                n_checks++;
                if (q[g] !== e[g]) begin
                    $display("FAIL tick dut%0d (SPEED=%0d CLK_PER_US=%0d) at %0t: o_q=%b expected=%b",
                             g, SP[g], CP[g], $time, q[g], e[g]);
                end else begin
                    n_pass++;
                end
            end
        end
    end

endmodule

// File: doc/timer_1us_tick.md
TIMER_1US_TICK -- requirements
Module: timer_1us_tick

Interface
REQ-001 SHALL have parameter SPEED, default 1, meaning the tick period in microseconds (integer, 1 to 2^24-1).
REQ-002 SHALL have parameter CLK_PER_US, default 25, meaning input clock cycles per microsecond (integer, 1 to 255).
REQ-003 SHALL have port i_clk_25MHz  input  1  meaning the single system clock; all logic is rising-edge triggered on it.
REQ-004 SHALL have port i_reset  input  1  meaning reset, asynchronous and active-high.
REQ-005 SHALL have port o_q  output  1  meaning a registered single-cycle tick pulse every SPEED microseconds.

Function
REQ-006 SHALL contain a prescaler counter of width ceil(log2(CLK_PER_US)), minimum 1 bit, counting 0 to CLK_PER_US-1 and wrapping to 0.
REQ-007 SHALL contain a microsecond counter of width ceil(log2(SPEED)), minimum 1 bit, advancing by 1 only on the cycle the prescaler wraps, counting 0 to SPEED-1 and wrapping to 0.
REQ-008 SHALL define the terminal condition as prescaler == CLK_PER_US-1 AND microsecond counter == SPEED-1.
REQ-009 SHALL register o_q = 1 on the edge where the terminal condition holds, and o_q = 0 on every other edge.
REQ-010 SHALL produce exactly one o_q pulse per N = SPEED*CLK_PER_US clock cycles, each pulse exactly one cycle wide.
REQ-011 SHALL have first-pulse latency after reset release such that o_q is high after the N-th rising edge and low again after edge N+1 (when N > 1).
REQ-012 SHALL hold o_q constantly high from the first edge after reset when N = 1.
REQ-013 SHALL never let either counter exceed its terminal value; any out-of-range value self-corrects to 0 on the next edge.
REQ-014 SHALL keep the pulse spacing at exactly N cycles indefinitely, with no drift or skipped pulse across counter wrap-around.
REQ-015 SHALL have no enable input; the timer runs continuously whenever reset is low.

Reset
REQ-016 SHALL, while i_reset = 1, immediately (asynchronously) force the prescaler to 0, the microsecond counter to 0 and o_q to 0, and hold them there.
REQ-017 SHALL, when reset is asserted mid-period (including during an o_q pulse), drop o_q at once and restart a full N-cycle period after release.
REQ-018 SHALL have release behaviour such that the first rising edge with i_reset = 0 counts as cycle 1 of the period.

Configuration
REQ-019 SHALL, with macro TIMER_1US_TICK_ASSERT_EN defined, compile in simulation/formal checks that: o_q is never high on two consecutive cycles when N > 1; both counters stay within range; o_q rises only on the terminal condition; and parameters are ≥ 1 (elaboration error otherwise).
REQ-020 SHALL, without TIMER_1US_TICK_ASSERT_EN, contain no checking logic, with identical functional behaviour.

Verification
REQ-021 SHALL pass this scenario: defaults (SPEED=1, CLK_PER_US=25), release reset -> o_q high only after edges 25, 50, 75; low otherwise.
REQ-022 SHALL pass this scenario: SPEED=4, CLK_PER_US=25, run 500 cycles -> exactly 5 pulses, at edges 100, 200, 300, 400, 500.
REQ-023 SHALL pass this scenario: SPEED=3, CLK_PER_US=5, assert reset asynchronously at cycle 7 for 2 cycles -> o_q and counters 0 immediately; next pulse 15 edges after release.
REQ-024 SHALL pass this scenario: SPEED=2, CLK_PER_US=5, assert reset exactly during a pulse cycle -> o_q falls without waiting for a clock edge; no pulse until 10 edges after release.
REQ-025 SHALL pass this scenario: SPEED=1, CLK_PER_US=1 -> o_q high continuously from the first edge after reset.
REQ-026 SHALL pass this scenario: SPEED=100000, CLK_PER_US=25, run 5,000,001 cycles -> exactly 2 pulses, at edges 2,500,000 and 5,000,000.
